// File: rtl/comp16_ctl.sv
`timescale 1ns/1ps
// comp16_ctl
//
// Sequencer in front of the comp16 compressor. It keeps a host-writable
// shadow gain table, streams it into comp16 over cin/cwe when the host asks
// for a load, and paces sample strobes so the compressor's 8-cycle serial
// multipliers are never overrun. Strobes that cannot be forwarded (during a
// load, or too soon after the previous one) are dropped and counted.
//
// Ports
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   hwa      in   host write address into the shadow table
//   hdi      in   host write data
//   hwe      in   host write enable (ignored while busy)
//   hld      in   load request pulse (ignored while busy)
//   hclr     in   clear dropcnt (wins over a simultaneous drop)
//   busy     out  load sequencer is not idle
//   six/siy  in   sample X/Y from the upstream source
//   siv      in   sample strobe
//   dix/diy  out  sample X/Y to comp16
//   iv       out  sample strobe to comp16, one cycle wide
//   cin      out  gain table data to comp16
//   cwe      out  gain table write enable to comp16
//   dropcnt  out  dropped-sample count, saturating
module comp16_ctl #(
  parameter int ENTRIES = 64,
  parameter int MINGAP  = 8,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [$clog2(ENTRIES)-1:0]   hwa,
  input  logic [COEF_W-1:0]            hdi,
  input  logic                         hwe,
  input  logic                         hld,
  input  logic                         hclr,
  output logic                         busy,
  input  logic signed [DATA_W-1:0]     six,
  input  logic signed [DATA_W-1:0]     siy,
  input  logic                         siv,
  output logic signed [DATA_W-1:0]     dix,
  output logic signed [DATA_W-1:0]     diy,
  output logic                         iv,
  output logic [COEF_W-1:0]            cin,
  output logic                         cwe,
  output logic [7:0]                   dropcnt
);

  localparam int AW = $clog2(ENTRIES);
  localparam int GW = $clog2(MINGAP + 1);
  localparam logic [AW-1:0] K_LAST     = AW'(ENTRIES - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(MINGAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    PREF  = 3'd2,
    LOAD  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      k;
  logic [GW-1:0]      gap;
  logic               idle;
  logic               fwd;
  logic               drop;
  logic [AW-1:0]      rd_addr;
  logic               cwe_nxt;
  logic [COEF_W-1:0]  cin_nxt;

  logic [COEF_W-1:0]  mem [ENTRIES];

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign idle = (state == IDLE);
  assign busy = ~idle;

  // A strobe goes through only when no load is in flight and the previous
  // forwarded strobe is at least MINGAP cycles old.
  assign fwd  = siv && idle && (gap == '0);
  assign drop = siv && !fwd;

  // Shadow table: data only, no reset, survives rstn.
  always_ff @(posedge clk) begin
    if (hwe && idle)
      mem[hwa] <= hdi;
  end

  // ---- load FSM: state register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---- load FSM: next state ----
  // WAIT is left when the gap counter is about to hit zero, so PREF lines
  // up with a quiet multiplier and WAIT never exceeds MINGAP-1 cycles.
  // A strobe forwarded on the same edge as hld reloads the gap counter, so
  // that load has to wait as well.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hld) state_nxt = ((gap != '0) || fwd) ? WAIT : PREF;
      WAIT:    if (gap <= GW'(1)) state_nxt = PREF;
      PREF:    state_nxt = LOAD;
      LOAD:    if (k == K_LAST) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- load FSM: outputs ----
  // cin/cwe are registered from the next state, so the table read is issued
  // one cycle ahead: entry 0 from PREF, entry k+1 while presenting entry k.
  always_comb begin
    rd_addr = (state == PREF) ? '0 : k + AW'(1);
    cwe_nxt = (state_nxt == LOAD);
    cin_nxt = cwe_nxt ? mem[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cwe <= 1'b0;
      cin <= '0;
    end else begin
      cwe <= cwe_nxt;
      cin <= cin_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      k <= '0;
    else if (state == PREF)
      k <= '0;
    else if (state == LOAD)
      k <= k + AW'(1);
  end

  // ---- sample path: gap counter and forwarding register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      gap <= '0;
    else if (fwd)
      gap <= GAP_RELOAD;
    else if (gap != '0)
      gap <= gap - GW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      iv  <= 1'b0;
      dix <= '0;
      diy <= '0;
    end else begin
      iv <= fwd;
      if (fwd) begin
        dix <= six;
        diy <= siy;
      end
    end
  end

  // ---- drop counter ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      dropcnt <= '0;
    else if (hclr)
      dropcnt <= '0;
    else if (drop)
      dropcnt <= sat_inc8(dropcnt);
  end

endmodule

// File: tb/tb_comp16_ctl.sv
`timescale 1ns/1ps
module tb_comp16_ctl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  hwa = '0;
  logic [7:0]  hdi = '0;
  logic        hwe = 1'b0;
  logic        hld = 1'b0;
  logic        hclr = 1'b0;
  logic        busy;
  logic [15:0] six = '0;
  logic [15:0] siy = '0;
  logic        siv = 1'b0;
  logic [15:0] dix;
  logic [15:0] diy;
  logic        iv;
  logic [7:0]  cin;
  logic        cwe;
  logic [7:0]  dropcnt;

  comp16_ctl dut (
    .clk(clk), .rstn(rstn), .hwa(hwa), .hdi(hdi), .hwe(hwe), .hld(hld),
    .hclr(hclr), .busy(busy), .six(six), .siy(siy), .siv(siv),
    .dix(dix), .diy(diy), .iv(iv), .cin(cin), .cwe(cwe), .dropcnt(dropcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int cyc; logic [15:0] x; logic [15:0] y; } samp_t;
  typedef struct { int cyc; logic [7:0] d; } coef_t;
  samp_t sq[$];
  coef_t cq[$];
  samp_t es;
  coef_t ec;
  logic [7:0] model [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents iv or cwe.
  always @(negedge clk) begin
    if (rstn) begin
      if (iv) begin
        if (sq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL iv_unexpected: got iv=1 dix=0x%0h, want no strobe (cycle %0d)", dix, cyc);
        end else begin
          es = sq.pop_front();
          check("iv_cycle", cyc, es.cyc);
          check("dix", dix, es.x);
          check("diy", diy, es.y);
        end
      end
      if (cwe) begin
        if (cq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cwe_unexpected: got cwe=1 cin=0x%0h, want cwe=0 (cycle %0d)", cin, cyc);
        end else begin
          ec = cq.pop_front();
          check("cwe_cycle", cyc, ec.cyc);
          check("cin", cin, ec.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int c);
    repeat (c) tick();
  endtask

  task automatic host_write(input int a, input logic [7:0] d, input bit taken);
    hwa = 6'(a); hdi = d; hwe = 1'b1;
    tick();
    hwe = 1'b0;
    if (taken) model[a] = d;
  endtask

  task automatic push_load(input int first);
    for (int j = 0; j < 64; j++) cq.push_back('{cyc: first + j, d: model[j]});
  endtask

  // hld for one cycle; off is the cycle distance from drive to first cwe.
  task automatic pulse_load(input int off, output int n);
    n = cyc;
    push_load(n + off);
    hld = 1'b1;
    tick();
    hld = 1'b0;
  endtask

  task automatic sample(input logic [15:0] x, input logic [15:0] y, input bit fwd);
    six = x; siy = y; siv = 1'b1;
    if (fwd) sq.push_back('{cyc: cyc + 1, x: x, y: y});
    tick();
    siv = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while ((sq.size() != 0 || cq.size() != 0) && b < budget) begin
      tick();
      b++;
    end
    check("queue_left", 32'(sq.size() + cq.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, want finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_iv", iv, 0);
    check("rst_cwe", cwe, 0);
    check("rst_cin", cin, 0);
    check("rst_dix", dix, 0);
    check("rst_diy", diy, 0);
    check("rst_dropcnt", dropcnt, 0);
    rstn = 1'b1;
    tick();

    // uniform table, load timing
    for (int a = 0; a < 64; a++) host_write(a, 8'h10, 1'b1);
    pulse_load(2, n);
    check("busy_rise", busy, 1);
    while (cyc < n + 66) tick();
    check("busy_last", busy, 1);
    tick();
    check("busy_fall", busy, 0);
    drain(10);

    // ordered table; write during LOAD must be ignored
    for (int a = 0; a < 64; a++)
      host_write(a, (a < 32) ? 8'h10 : (a < 48) ? 8'h20 : (a < 56) ? 8'h40 : 8'h80, 1'b1);
    pulse_load(2, n);
    idle_n(10);
    host_write(0, 8'hFF, 1'b0);
    drain(100);
    idle_n(4);
    pulse_load(2, n);
    drain(100);
    idle_n(4);

    // pacing: 32-cycle cadence, nothing dropped
    for (int i = 0; i < 256; i++) begin
      sample(16'(i * 256), 16'h7FFF - 16'(i), 1'b1);
      idle_n(31);
    end
    drain(5);
    check("pace_dropcnt", dropcnt, 0);

    // overrun: strobes at relative cycles 0, 3, 8
    idle_n(10);
    sample(16'h1234, 16'hA001, 1'b1);
    idle_n(2);
    sample(16'h5678, 16'hA002, 1'b0);
    idle_n(4);
    sample(16'h9ABC, 16'hA003, 1'b1);
    idle_n(2);
    check("overrun_dropcnt", dropcnt, 1);
    hclr = 1'b1; tick(); hclr = 1'b0;
    check("overrun_clr", dropcnt, 0);
    drain(5);

    // simultaneous siv + hld, then strobes blocked by the load
    idle_n(10);
    n = cyc;
    push_load(n + 9);
    hld = 1'b1;
    sample(16'hC001, 16'hD001, 1'b1);
    hld = 1'b0;
    while (cyc < n + 32) tick();
    sample(16'hC002, 16'hD002, 1'b0);
    while (cyc < n + 64) tick();
    sample(16'hC003, 16'hD003, 1'b0);
    idle_n(2);
    check("blocked_dropcnt", dropcnt, 2);
    hclr = 1'b1; tick(); hclr = 1'b0;
    check("blocked_clr", dropcnt, 0);
    while (cyc < n + 96) tick();
    sample(16'hC004, 16'hD004, 1'b1);
    drain(100);
    idle_n(4);

    // reset in the middle of a load, at k=20
    idle_n(10);
    pulse_load(2, n);
    while (cyc < n + 22) tick();
    check("midload_cwe", cwe, 1);
    check("midload_cin", cin, model[20]);
    check("midload_pending", 32'(cq.size()), 32'd44);
    rstn = 1'b0;
    cq.delete();
    #1;
    check("midrst_cwe", cwe, 0);
    check("midrst_cin", cin, 0);
    check("midrst_busy", busy, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("midrst_dropcnt", dropcnt, 0);
    pulse_load(2, n);
    drain(100);
    idle_n(4);
    check("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
